// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Pulls words from a fixed-latency upstream FIFO and presents them on a
// valid/ready stream. A small circular output buffer absorbs the FIFO read
// latency. Reads are only issued when the space they need is already free, so
// a beat accepted downstream never feeds straight into the read decision.
// Each beat is tagged with m_last at burst boundaries, accepted beats are
// counted, and any write into a full buffer sets a sticky error.

module fifo_stream_reader #(
   parameter int DATA_WIDTH      = 64,
   parameter int RD_LATENCY      = 2,
   parameter int OBUF_DEPTH_BITS = 2,
   parameter int BURST_LEN       = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  fifo_empty,
   output logic                  fifo_re,
   input  logic                  fifo_valid,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic [31:0]           beat_count,
   output logic                  overflow_err
);

   localparam int DEPTH = 2 ** OBUF_DEPTH_BITS;
   localparam int PTR_W = OBUF_DEPTH_BITS;
   localparam int CNT_W = OBUF_DEPTH_BITS + 1;

   localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE_C    = PTR_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ONE_C    = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ZERO_C   = CNT_W'(1'b0);
   localparam logic [15:0]      BURST_LAST_C = 16'(BURST_LEN - 1);

   // Buffer storage; contents are don't-care after reset.
   logic [DATA_WIDTH-1:0] obuf_mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q,       wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q,       rd_ptr_d;
   logic [CNT_W-1:0] obuf_cnt_q,     obuf_cnt_d;
   logic [CNT_W-1:0] inflight_q,     inflight_d;
   logic [15:0]      burst_cnt_q,    burst_cnt_d;
   logic [31:0]      beat_count_q,   beat_count_d;
   logic             overflow_err_q, overflow_err_d;

   logic             handshake_s;
   logic             full_s;
   logic             wr_en_s;
   logic             fifo_re_s;
   logic [CNT_W:0]   occupancy_s;

   // Stream side is driven straight from registered state.
   assign m_valid      = (obuf_cnt_q != CNT_ZERO_C);
   assign m_data       = obuf_mem_q[rd_ptr_q];
   assign m_last       = m_valid & (burst_cnt_q == BURST_LAST_C);
   assign beat_count   = beat_count_q;
   assign overflow_err = overflow_err_q;
   assign fifo_re      = fifo_re_s;

   // Read issue and buffer write decisions; occupancy uses registered counts only.
   always_comb begin
      handshake_s = m_valid & m_ready;
      full_s      = (obuf_cnt_q == DEPTH_C);
      occupancy_s = {1'b0, obuf_cnt_q} + {1'b0, inflight_q};
      fifo_re_s   = reset_n & ~fifo_empty & (occupancy_s < {1'b0, DEPTH_C});
      // A full buffer can still take a word when the head leaves this cycle.
      wr_en_s     = reset_n & fifo_valid & (~full_s | handshake_s);
   end

   // Next-state computation for pointers, counters and the error flag.
   always_comb begin
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      obuf_cnt_d     = obuf_cnt_q;
      inflight_d     = inflight_q;
      burst_cnt_d    = burst_cnt_q;
      beat_count_d   = beat_count_q;
      overflow_err_d = overflow_err_q;

      if (wr_en_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE_C;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (handshake_s) begin
         rd_ptr_d     = rd_ptr_q + PTR_ONE_C;
         beat_count_d = beat_count_q + 32'd1;
         if (burst_cnt_q == BURST_LAST_C) begin
            burst_cnt_d = 16'd0;
         end else begin
            burst_cnt_d = burst_cnt_q + 16'd1;
         end
      end else begin
         rd_ptr_d     = rd_ptr_q;
         beat_count_d = beat_count_q;
         burst_cnt_d  = burst_cnt_q;
      end

      case ({wr_en_s, handshake_s})
         2'b10:   obuf_cnt_d = obuf_cnt_q + CNT_ONE_C;
         2'b01:   obuf_cnt_d = obuf_cnt_q - CNT_ONE_C;
         default: obuf_cnt_d = obuf_cnt_q;
      endcase

      // A return with nothing outstanding is ignored rather than wrapping.
      case ({fifo_re_s, fifo_valid})
         2'b10: inflight_d = inflight_q + CNT_ONE_C;
         2'b01: begin
            if (inflight_q != CNT_ZERO_C) begin
               inflight_d = inflight_q - CNT_ONE_C;
            end else begin
               inflight_d = inflight_q;
            end
         end
         default: inflight_d = inflight_q;
      endcase

      if (fifo_valid & full_s & ~handshake_s) begin
         overflow_err_d = 1'b1;
      end else begin
         overflow_err_d = overflow_err_q;
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         obuf_cnt_q     <= '0;
         inflight_q     <= '0;
         burst_cnt_q    <= 16'd0;
         beat_count_q   <= 32'd0;
         overflow_err_q <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         obuf_cnt_q     <= obuf_cnt_d;
         inflight_q     <= inflight_d;
         burst_cnt_q    <= burst_cnt_d;
         beat_count_q   <= beat_count_d;
         overflow_err_q <= overflow_err_d;
      end
   end

   // Buffer write port; dropped writes never touch the array.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         obuf_mem_q[wr_ptr_q] <= fifo_dout;
      end
   end

   fifo_stream_reader_chk #(
      .DATA_WIDTH      (DATA_WIDTH),
      .RD_LATENCY      (RD_LATENCY),
      .OBUF_DEPTH_BITS (OBUF_DEPTH_BITS)
   ) u_chk (
      .clk        (clk),
      .reset_n    (reset_n),
      .obuf_cnt_i (obuf_cnt_q),
      .inflight_i (inflight_q),
      .m_valid_i  (m_valid),
      .m_ready_i  (m_ready),
      .m_data_i   (m_data),
      .m_last_i   (m_last)
   );

endmodule

// Invariants of the reader: credit never exceeds buffer space, outstanding
// reads are bounded by the read latency, and a stalled beat holds still.
module fifo_stream_reader_chk #(
   parameter int DATA_WIDTH      = 64,
   parameter int RD_LATENCY      = 2,
   parameter int OBUF_DEPTH_BITS = 2
) (
   input logic                       clk,
   input logic                       reset_n,
   input logic [OBUF_DEPTH_BITS:0]   obuf_cnt_i,
   input logic [OBUF_DEPTH_BITS:0]   inflight_i,
   input logic                       m_valid_i,
   input logic                       m_ready_i,
   input logic [DATA_WIDTH-1:0]      m_data_i,
   input logic                       m_last_i
);

   localparam int CNT_W = OBUF_DEPTH_BITS + 1;
   localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(2 ** OBUF_DEPTH_BITS);
   localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(RD_LATENCY);

   a_credit_bound: assert property (@(posedge clk) disable iff (!reset_n)
      (({1'b0, obuf_cnt_i} + {1'b0, inflight_i}) <= DEPTH_W));

   a_inflight_bound: assert property (@(posedge clk) disable iff (!reset_n)
      (inflight_i <= LAT_C));

   a_stall_stable: assert property (@(posedge clk) disable iff (!reset_n)
      (m_valid_i && !m_ready_i) |=> ($stable(m_data_i) && $stable(m_last_i) && m_valid_i));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: an upstream FIFO model with a
// fixed read latency feeds the DUT; a scoreboard queue holds words in write
// order and every accepted beat is compared against it.

module tb_fifo_stream_reader;

   localparam int DW    = 64;
   localparam int L     = 2;
   localparam int BL    = 8;
   localparam int DEPTH = 4;

   logic          clk;
   logic          reset_n;
   logic          fifo_empty;
   logic          fifo_re;
   logic          fifo_valid;
   logic [DW-1:0] fifo_dout;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic [31:0]   beat_count;
   logic          overflow_err;

   fifo_stream_reader #(
      .DATA_WIDTH      (DW),
      .RD_LATENCY      (L),
      .OBUF_DEPTH_BITS (2),
      .BURST_LEN       (BL)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .fifo_empty   (fifo_empty),
      .fifo_re      (fifo_re),
      .fifo_valid   (fifo_valid),
      .fifo_dout    (fifo_dout),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .beat_count   (beat_count),
      .overflow_err (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int n_words;
      int exp_re;
      bit exp_mvalid;
   } vec_t;

   int            n_pass  = 0;
   int            n_total = 0;
   logic [DW-1:0] up_q [$];
   logic [DW-1:0] exp_q [$];
   bit            pv [1:L];
   logic [DW-1:0] pd [1:L];
   bit            force_v;
   logic [DW-1:0] force_d;
   int            accepted;
   int            out_cnt;
   int            max_out;
   bit            s_re, s_mv, s_ml, s_hs;
   logic [DW-1:0] s_md;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push_word();
      logic [DW-1:0] w;
      w = {$urandom(), $urandom()};
      up_q.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic clear_models();
      up_q.delete();
      exp_q.delete();
      for (int k = 1; k <= L; k++) begin
         pv[k] = 1'b0;
         pd[k] = '0;
      end
      accepted = 0;
      out_cnt  = 0;
   endtask

   // One clock cycle: drive inputs, sample just after, score, then model the edge.
   task automatic tick();
      fifo_empty = (up_q.size() == 0);
      fifo_valid = pv[L] | force_v;
      fifo_dout  = force_v ? force_d : pd[L];
      #1;
      s_re = fifo_re;
      s_mv = m_valid;
      s_md = m_data;
      s_ml = m_last;
      s_hs = m_valid & m_ready;
      if (!reset_n) begin
         check("re_in_reset", s_re, 0);
      end else begin
         if (s_re) check("re_nonempty", up_q.size() != 0, 1);
         if (s_hs) begin
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("data_order", s_md, exp_q.pop_front());
            check("m_last", s_ml, (accepted % BL) == BL - 1);
            accepted++;
         end
         out_cnt = out_cnt + int'(s_re) - int'(s_hs);
         if (out_cnt > max_out) max_out = out_cnt;
      end
      @(posedge clk);
      if (!reset_n) begin
         clear_models();
      end else begin
         for (int k = L; k >= 2; k--) begin
            pv[k] = pv[k-1];
            pd[k] = pd[k-1];
         end
         pv[1] = s_re;
         pd[1] = (s_re && up_q.size() != 0) ? up_q.pop_front() : '0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      m_ready = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      #1;
   endtask

   vec_t          tbl [5];
   int            re_cnt, first_re, first_mv, first_hs, last_hs, n_last, pushed;
   logic [DW-1:0] d_early;

   initial begin
      reset_n    = 1'b0;
      m_ready    = 1'b0;
      fifo_empty = 1'b1;
      fifo_valid = 1'b0;
      fifo_dout  = '0;
      force_v    = 1'b0;
      force_d    = '0;
      max_out    = 0;
      clear_models();
      @(negedge clk);

      // Reset state
      do_reset();
      check("rst_m_valid", m_valid, 0);
      check("rst_m_last", m_last, 0);
      check("rst_beat_count", beat_count, 0);
      check("rst_overflow", overflow_err, 0);
      check("rst_fifo_re_empty", fifo_re, 0);

      // Preload n words, stall, then drain
      tbl[0] = '{n_words: 0,  exp_re: 0, exp_mvalid: 1'b0};
      tbl[1] = '{n_words: 1,  exp_re: 1, exp_mvalid: 1'b1};
      tbl[2] = '{n_words: 3,  exp_re: 3, exp_mvalid: 1'b1};
      tbl[3] = '{n_words: 4,  exp_re: 4, exp_mvalid: 1'b1};
      tbl[4] = '{n_words: 20, exp_re: 4, exp_mvalid: 1'b1};
      foreach (tbl[v]) begin
         do_reset();
         for (int i = 0; i < tbl[v].n_words; i++) push_word();
         re_cnt  = 0;
         d_early = '0;
         for (int i = 0; i < 12; i++) begin
            tick();
            re_cnt += int'(s_re);
            if (i == 5) d_early = s_md;
         end
         check("tbl_re_pulses", re_cnt, tbl[v].exp_re);
         check("tbl_mvalid", s_mv, tbl[v].exp_mvalid);
         if (tbl[v].exp_mvalid) begin
            check("tbl_hold_data", s_md, d_early);
            if (exp_q.size() != 0) check("tbl_head", s_md, exp_q[0]);
         end
         m_ready = 1'b1;
         for (int i = 0; i < 40; i++) begin
            tick();
            re_cnt += int'(s_re);
         end
         check("tbl_drained", exp_q.size(), 0);
         check("tbl_total_re", re_cnt, tbl[v].n_words);
         check("tbl_beats", beat_count, tbl[v].n_words);
         check("tbl_mvalid_end", m_valid, 0);
      end

      // Latency, full throughput and burst marking for 20 words
      do_reset();
      for (int i = 0; i < 20; i++) push_word();
      m_ready  = 1'b1;
      first_re = -1; first_mv = -1; first_hs = -1; last_hs = -1; n_last = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (s_re && first_re < 0) first_re = i;
         if (s_mv && first_mv < 0) first_mv = i;
         if (s_hs) begin
            if (first_hs < 0) first_hs = i;
            last_hs = i;
            if (s_ml) n_last++;
         end
      end
      check("first_re_cycle", first_re, 0);
      check("first_mvalid_latency", first_mv - first_re, L + 1);
      check("consecutive_beats", last_hs - first_hs, 19);
      check("last_count", n_last, 2);
      check("beats_20", beat_count, 20);
      check("accepted_20", accepted, 20);

      // Forced write into a full buffer
      do_reset();
      for (int i = 0; i < 4; i++) push_word();
      for (int i = 0; i < 8; i++) tick();
      check("ovf_full_mvalid", m_valid, 1);
      check("ovf_pre_err", overflow_err, 0);
      check("ovf_pre_head", m_data, exp_q[0]);
      force_v = 1'b1;
      force_d = 64'hDEAD_BEEF_0BAD_F00D;
      tick();
      force_v = 1'b0;
      check("ovf_err_set", overflow_err, 1);
      check("ovf_head_kept", m_data, exp_q[0]);
      for (int i = 0; i < 3; i++) tick();
      check("ovf_err_sticky", overflow_err, 1);
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("ovf_drained", exp_q.size(), 0);
      check("ovf_no_extra", m_valid, 0);
      check("ovf_beats", beat_count, 4);
      // Reads must still flow after the unmatched return
      push_word();
      for (int i = 0; i < 10; i++) tick();
      check("ovf_after_word", accepted, 5);
      check("ovf_err_still", overflow_err, 1);
      do_reset();
      check("ovf_err_cleared", overflow_err, 0);

      // Reset with reads in flight and words buffered
      for (int i = 0; i < 3; i++) push_word();
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("pre_rst_accepted", accepted, 3);
      m_ready = 1'b0;
      for (int i = 0; i < 10; i++) push_word();
      for (int i = 0; i < 4; i++) tick();
      check("pre_rst_buffered", m_valid, 1);
      do_reset();
      check("post_rst_mvalid", m_valid, 0);
      check("post_rst_beats", beat_count, 0);
      check("post_rst_overflow", overflow_err, 0);
      check("post_rst_last", m_last, 0);
      for (int i = 0; i < 8; i++) push_word();
      m_ready = 1'b1;
      n_last  = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (s_hs && s_ml) n_last++;
      end
      check("post_rst_accepted", accepted, 8);
      check("post_rst_burst_last", n_last, 1);

      // Random traffic against the scoreboard
      do_reset();
      max_out = 0;
      pushed  = 0;
      for (int c = 0; c < 60000 && accepted < 10000; c++) begin
         if (pushed < 10000 && $urandom_range(1, 0) == 1) begin
            push_word();
            pushed++;
         end
         m_ready = ($urandom_range(1, 0) == 1);
         tick();
      end
      check("rand_accepted", accepted, 10000);
      check("rand_queue_empty", exp_q.size(), 0);
      check("rand_overflow", overflow_err, 0);
      check("rand_max_outstanding_ok", max_out <= DEPTH, 1);
      check("rand_beats", beat_count, 10000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
